// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch-side lookup and execute-side update/mispredict detection.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PC,
    output logic             hit,
    output logic             taken,
    output logic [31:0]      pred_PC,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_PC,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_PC,
    output logic             mispredict,
    output logic [31:0]      redirect_PC,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    logic [1:0]         ctr_mem [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_upd;
    logic             ex_hit;
    logic             alloc;
    logic [1:0]       ctr_next;

    // Fetch-side lookup: pure read of the current table contents.
    always_comb begin
        lk_idx  = PC[IDX_W+1:2];
        lk_tag  = PC[31:IDX_W+2];
        lk_hit  = rst & valid[lk_idx] & (tag_mem[lk_idx] == lk_tag);
        hit     = lk_hit;
        taken   = lk_hit & ctr_mem[lk_idx][1];
        pred_PC = lk_hit ? tgt_mem[lk_idx] : 32'd0;
    end

    // Execute-side resolution and outcome checking.
    always_comb begin
        ex_idx      = ex_PC[IDX_W+1:2];
        ex_tag      = ex_PC[31:IDX_W+2];
        ex_upd      = ex_valid & ex_is_branch;
        ex_hit      = valid[ex_idx] & (tag_mem[ex_idx] == ex_tag);
        alloc       = ex_upd & ~ex_hit & ex_taken;
        mispredict  = rst & ex_upd &
                      ((ex_taken != ex_pred_taken) |
                       (ex_taken & ex_pred_taken & (ex_target != ex_pred_PC)));
        redirect_PC = 32'd0;
        if (mispredict) begin
            redirect_PC = ex_taken ? ex_target : ex_PC + 32'd4;
        end
        ctr_next = ctr_mem[ex_idx];
        if (ex_taken) begin
            if (ctr_mem[ex_idx] != 2'b11) ctr_next = ctr_mem[ex_idx] + 2'd1;
        end else begin
            if (ctr_mem[ex_idx] != 2'b00) ctr_next = ctr_mem[ex_idx] - 2'd1;
        end
    end

    // Valid bits and direction counters carry reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) ctr_mem[i] <= 2'b01;
        end else if (ex_upd) begin
            if (ex_hit) begin
                ctr_mem[ex_idx] <= ctr_next;
            end else if (ex_taken) begin
                valid[ex_idx]   <= 1'b1;
                ctr_mem[ex_idx] <= 2'b10;
            end
        end
    end

    // Tags and targets are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (alloc) tag_mem[ex_idx] <= ex_tag;
        if (ex_upd & ex_taken) tgt_mem[ex_idx] <= ex_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        hit;
    logic        taken;
    logic [31:0] pred_PC;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_PC;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_PC;
    logic        mispredict;
    logic [31:0] redirect_PC;
    logic [15:0] mispredict_cnt;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.ENTRIES(16), .IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .PC(PC), .hit(hit), .taken(taken), .pred_PC(pred_PC),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_PC(ex_PC),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_PC(ex_pred_PC), .mispredict(mispredict), .redirect_PC(redirect_PC),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ppc);
        ex_valid = v; ex_is_branch = br; ex_PC = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_PC = ppc;
    endtask

    // Advance one edge, then leave a settle gap before checking outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                        input logic [31:0] ep, input string tag);
        PC = pc;
        #1;
        check({tag, ".hit"}, 32'(hit), 32'(eh));
        check({tag, ".taken"}, 32'(taken), 32'(et));
        check({tag, ".pred"}, pred_PC, ep);
    endtask

    initial begin
        rst = 1'b0;
        PC  = 32'h100;
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'd0);
        repeat (2) tick();

        // 1: reset state; outputs held low even with a live mispredict request
        look(32'h100, 1'b0, 1'b0, 32'd0, "rst");
        check("rst.cnt", 32'(mispredict_cnt), 32'd0);
        check("rst.mp", 32'(mispredict), 32'd0);
        check("rst.redir", redirect_PC, 32'd0);
        idle();
        rst = 1'b1;
        tick();

        // 2: first taken resolution allocates entry
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'd0);
        #1;
        check("s2.mp", 32'(mispredict), 32'd1);
        check("s2.redir", redirect_PC, 32'h200);
        tick();
        idle();
        look(32'h100, 1'b1, 1'b1, 32'h200, "s2.lk");
        check("s2.cnt", 32'(mispredict_cnt), 32'd1);
        check("s2.mp_idle", 32'(mispredict), 32'd0);

        // 3: two not-taken resolutions, 10 -> 01 -> 00
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        check("s3.mp", 32'(mispredict), 32'd1);
        check("s3.redir", redirect_PC, 32'h104);
        tick();
        idle();
        look(32'h100, 1'b1, 1'b0, 32'h200, "s3.lk1");
        check("s3.cnt", 32'(mispredict_cnt), 32'd2);
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("s3.nomp", 32'(mispredict), 32'd0);
        check("s3.nomp_redir", redirect_PC, 32'd0);
        tick();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        // counter must stay at 00 and step only to 01, still not taken
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        #1;
        check("s3.tk_nomp", 32'(mispredict), 32'd0);
        tick();
        idle();
        look(32'h100, 1'b1, 1'b0, 32'h200, "s3.sat_lo");
        check("s3.cnt2", 32'(mispredict_cnt), 32'd2);

        // 4: same-index eviction by 0x140; not-taken miss does not evict
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        tick();
        drive_ex(1'b1, 1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
        tick();
        idle();
        look(32'h100, 1'b0, 1'b0, 32'd0, "s4.evicted");
        look(32'h140, 1'b1, 1'b1, 32'h500, "s4.new");
        check("s4.cnt", 32'(mispredict_cnt), 32'd3);
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        look(32'h143, 1'b1, 1'b1, 32'h500, "s4.alias");

        // 5: same-cycle lookup sees old target, new one next cycle
        PC = 32'h140;
        drive_ex(1'b1, 1'b1, 32'h140, 1'b1, 32'h600, 1'b1, 32'h500);
        #1;
        check("s5.old", pred_PC, 32'h500);
        check("s5.mp", 32'(mispredict), 32'd1);
        check("s5.redir", redirect_PC, 32'h600);
        tick();
        idle();
        look(32'h140, 1'b1, 1'b1, 32'h600, "s5.new");
        // ctr now 11; another taken must saturate, then one not-taken leaves 10
        drive_ex(1'b1, 1'b1, 32'h140, 1'b1, 32'h600, 1'b1, 32'h600);
        tick();
        drive_ex(1'b1, 1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h600);
        tick();
        idle();
        look(32'h140, 1'b1, 1'b1, 32'h600, "s5.sat_hi");
        check("s5.cnt", 32'(mispredict_cnt), 32'd5);
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
        #1;
        check("s5.tgt_mp", 32'(mispredict), 32'd1);
        check("s5.tgt_redir", redirect_PC, 32'h200);
        tick();
        drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        #1;
        check("s5.wrap", redirect_PC, 32'h0);
        drive_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h700, 1'b0, 32'h0);
        #1;
        check("s5.nobr_mp", 32'(mispredict), 32'd0);
        tick();
        idle();
        look(32'h100, 1'b1, 1'b1, 32'h200, "s5.nobr_keep");
        check("s5.cnt2", 32'(mispredict_cnt), 32'd6);

        // 6: asynchronous reset mid-sequence
        #2;
        rst = 1'b0;
        #1;
        look(32'h100, 1'b0, 1'b0, 32'd0, "s6.rst");
        check("s6.cnt0", 32'(mispredict_cnt), 32'd0);
        tick();
        rst = 1'b1;
        drive_ex(1'b1, 1'b1, 32'h80, 1'b1, 32'h900, 1'b0, 32'h0);
        tick();
        check("s6.first", 32'(mispredict_cnt), 32'd1);
        repeat (65538) @(posedge clk);
        #1;
        check("s6.sat", 32'(mispredict_cnt), 32'h0000_FFFF);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Branch target buffer with 2-bit saturating direction counters. It sits directly upstream of the instruction fetch stage and drives its hit/taken/pred_PC inputs each cycle from the current fetch PC. Execute feeds back resolved branch and jump outcomes. The block updates its tables and flags mispredictions, giving a redirect PC to the pipeline flush logic.

Parameters:
ENTRIES, 16, number of BTB entries (power of 2, >=2)
IDX_W, 4, log2(ENTRIES); index = PC[IDX_W+1:2]
CNT_W, 16, width of the saturating mispredict statistics counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
PC  input  32  current fetch PC (lookup address)
hit  output  1  lookup found a valid entry with matching tag
taken  output  1  predicted taken (hit & counter MSB)
pred_PC  output  32  predicted target; 0 when hit=0
ex_valid  input  1  execute-stage result valid this cycle
ex_is_branch  input  1  resolved instruction is a branch or jal/jalr
ex_PC  input  32  PC of the resolved instruction
ex_taken  input  1  actual direction
ex_target  input  32  actual target address
ex_pred_taken  input  1  prediction that was made for ex_PC (piped down)
ex_pred_PC  input  32  predicted target that was used (piped down)
mispredict  output  1  resolved outcome differs from prediction
redirect_PC  output  32  correct next PC when mispredict=1
mispredict_cnt  output  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (rst=0, async): all valid bits=0, all counters=2'b01, mispredict_cnt=0. Combinational outputs during reset: hit=0, taken=0, pred_PC=0, mispredict=0, redirect_PC=0.
- Entry layout: valid, tag=PC[31:IDX_W+2], target[31:0], ctr[1:0]. Direct-mapped.
- Lookup is combinational, zero latency. Fetch latches PC_next on the same edge.
  - hit = valid[idx] & (tag[idx]==PC tag).
  - taken = hit & ctr[idx][1].
  - pred_PC = hit ? target[idx] : 0.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturating: ex_taken increments, not-taken decrements; 11+1=11, 00-1=00.
- Update on posedge clk when ex_valid & ex_is_branch, using the ex_PC index/tag:
  - Tag hit: update ctr; if ex_taken, target<=ex_target. The target is unchanged when not taken.
  - Tag miss and ex_taken: allocate (overwrite) with valid=1, new tag, target=ex_target, ctr=2'b10.
  - Tag miss and not taken: no allocation, tables unchanged.
- ex_valid=0 or ex_is_branch=0: no table change, mispredict=0.
- Mispredict (combinational) = ex_valid & ex_is_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_PC)).
- redirect_PC = ex_taken ? ex_target : ex_PC+32'd4 (mod 2^32). It equals 0 when mispredict=0.
- mispredict_cnt increments on each clock where mispredict=1. It saturates at all-ones.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns the pre-update contents. The new contents are visible from the next cycle.
- Aliasing: a different tag at the same index evicts on taken allocation only.
- Reset asserted mid-operation clears all state immediately. The first edge after release performs normal operation.
- PC[1:0] and ex_PC[1:0] are ignored for index and tag.

Test Plan:
1. Reset, then PC=0x100 -> hit=0, taken=0, pred_PC=0, mispredict_cnt=0.
2. Resolve ex_PC=0x100 taken to 0x200 with ex_pred_taken=0 -> mispredict=1, redirect_PC=0x200. Next cycle, PC=0x100 gives hit=1, taken=1 (ctr=10), pred_PC=0x200, and mispredict_cnt=1.
3. From the step 2 state, resolve 0x100 not-taken twice -> ctr 10->01->00. Lookup gives hit=1, taken=0. The first resolution (pred_taken=1) gives mispredict=1, redirect_PC=0x104.
4. Resolve taken ex_PC=0x100 and ex_PC=0x140 (same index, ENTRIES=16) on consecutive cycles -> the 0x140 entry evicts 0x100. PC=0x100 then misses and PC=0x140 hits.
5. Drive PC=0x100 while updating 0x100 the same cycle -> the lookup shows old data, and the new data appears next cycle. Resolve a taken branch with ex_pred_taken=1 but ex_pred_PC=0x300 versus ex_target=0x200 -> mispredict=1, redirect_PC=0x200.
6. Assert rst low mid-sequence with populated entries -> hit=0 immediately for all PCs. Force 2^CNT_W+3 mispredicts -> mispredict_cnt holds 0xFFFF.
